tdm_mux4: RTL and testbench

TDM_MUX4 -- requirements
Module: tdm_mux4

---
 rtl/tdm_pkg.sv | 8 +
 rtl/rr_arb4.sv | 31 +++
 rtl/tdm_mux4.sv | 97 +++++++++
 tb/tb_tdm_mux4.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants for the four-channel TDM merge and its round-robin arbiter.
package tdm_pkg;

    localparam int unsigned N_CH      = 4;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned DEF_WIDTH = 8;

endpackage

// File: rtl/rr_arb4.sv
// Combinational four-way round-robin arbiter: search starts one past ptr and wraps.
module rr_arb4
    import tdm_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] idx
);

    logic             found;
    logic [SEL_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = ptr;
        found = 1'b0;
        cand  = '0;
        // Offsets 1..4 visit ptr+1 first and ptr itself last.
        for (int k = 1; k <= int'(N_CH); k++) begin
            cand = ptr + SEL_W'(k);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_mux4.sv
// Merges four valid/ready channels into one registered stream tagged with its source index.
module tdm_mux4
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             v0,
    input  logic             v1,
    input  logic             v2,
    input  logic             v3,
    output logic             r0,
    output logic             r1,
    output logic             r2,
    output logic             r3,
    output logic [WIDTH-1:0] d,
    output logic [SEL_W-1:0] s,
    output logic             y_valid,
    input  logic             y_ready
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic [WIDTH-1:0] d_nxt;
    logic [SEL_W-1:0] s_nxt;
    logic             y_valid_nxt;
    logic [N_CH-1:0]  gnt;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] dsel;
    logic             free;
    logic             arb_en;
    logic             any_gnt;

    // Output slot can take a word when empty or being drained this cycle; never during reset.
    assign free    = !y_valid || y_ready;
    assign arb_en  = free && rst_n;
    assign any_gnt = |gnt;

    rr_arb4 u_arb (
        .req (   {v3, v2, v1, v0}),
        .ptr (   ptr),
        .en  (   arb_en),
        .gnt (   gnt),
        .idx (   idx)
    );

    assign r0 = gnt[0];
    assign r1 = gnt[1];
    assign r2 = gnt[2];
    assign r3 = gnt[3];

    always_comb begin
        dsel = d0;
        case (idx)
            2'd0:    dsel = d0;
            2'd1:    dsel = d1;
            2'd2:    dsel = d2;
            default: dsel = d3;
        endcase
    end

    always_comb begin
        d_nxt       = d;
        s_nxt       = s;
        y_valid_nxt = y_valid;
        ptr_nxt     = ptr;
        if (any_gnt) begin
            d_nxt       = dsel;
            s_nxt       = idx;
            y_valid_nxt = 1'b1;
            ptr_nxt     = idx;
        end else if (y_ready) begin
            y_valid_nxt = 1'b0;
        end
    end

    // Reset leaves ptr at 3 so channel 0 is first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d       <= '0;
            s       <= '0;
            y_valid <= 1'b0;
            ptr     <= SEL_W'(N_CH - 1);
        end else begin
            d       <= d_nxt;
            s       <= s_nxt;
            y_valid <= y_valid_nxt;
            ptr     <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_tdm_mux4.sv
// Directed self-checking bench for tdm_mux4, with a behavioural demux4 on the output.
module tb_tdm_mux4;

    logic       clk;
    logic       rst_n;
    logic [7:0] d0, d1, d2, d3;
    logic       v0, v1, v2, v3;
    logic       r0, r1, r2, r3;
    logic [7:0] d;
    logic [1:0] s;
    logic       y_valid;
    logic       y_ready;

    int nchecks;
    int nerrors;

    // Demux model: toggles yd[i] and counts every consumed word tagged with s=i.
    logic [3:0] yd;
    int         cons [4];

    tdm_mux4 #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .v0      (v0),
        .v1      (v1),
        .v2      (v2),
        .v3      (v3),
        .r0      (r0),
        .r1      (r1),
        .r2      (r2),
        .r3      (r3),
        .d       (d),
        .s       (s),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && y_valid && y_ready) begin
            yd[s]   <= ~yd[s];
            cons[s] = cons[s] + 1;
        end
    end

    task automatic test_reset();
        logic [3:0] rv;
        @(negedge clk);
        rst_n = 1'b0;
        v0 = 1'b1; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        y_ready = 1'b0;
        #1;
        rv = {r3, r2, r1, r0};
        nchecks++;
        if (rv !== 4'b0000) begin
            nerrors++;
            $display("FAIL reset_ready: r=%b expected 0000", rv);
        end
        v0 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rv = {r3, r2, r1, r0};
            nchecks++;
            if (y_valid !== 1'b0 || d !== 8'h00 || s !== 2'd0 || rv !== 4'b0000) begin
                nerrors++;
                $display("FAIL reset_idle: y_valid=%b d=%h s=%0d r=%b expected 0 00 0 0000",
                         y_valid, d, s, rv);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] dv [4];
        logic [3:0] rv;
        int         ch;
        dv[0] = 8'h10; dv[1] = 8'h21; dv[2] = 8'h32; dv[3] = 8'h43;
        @(negedge clk);
        d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
        v0 = 1'b1; v1 = 1'b1; v2 = 1'b1; v3 = 1'b1;
        y_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ch = i % 4;
            #1;
            rv = {r3, r2, r1, r0};
            nchecks++;
            if (rv !== 4'(1 << ch)) begin
                nerrors++;
                $display("FAIL rr_ready[%0d]: r=%b expected %b", i, rv, 4'(1 << ch));
            end
            @(posedge clk); #1;
            nchecks++;
            if (y_valid !== 1'b1 || s !== 2'(ch) || d !== dv[ch]) begin
                nerrors++;
                $display("FAIL rr_out[%0d]: y_valid=%b s=%0d d=%h expected 1 %0d %h",
                         i, y_valid, s, d, ch, dv[ch]);
            end
            @(negedge clk);
        end
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        @(posedge clk); #1;
        nchecks++;
        if (y_valid !== 1'b0 || s !== 2'd3 || d !== 8'h43) begin
            nerrors++;
            $display("FAIL rr_drain: y_valid=%b s=%0d d=%h expected 0 3 43", y_valid, s, d);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        cons[2] = 0;
        d2 = 8'hA5; v2 = 1'b1; y_ready = 1'b0;
        #1;
        nchecks++;
        if (r2 !== 1'b1) begin
            nerrors++;
            $display("FAIL bp_first_ready: r2=%b expected 1", r2);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            nchecks++;
            if (y_valid !== 1'b1 || s !== 2'd2 || d !== 8'hA5) begin
                nerrors++;
                $display("FAIL bp_hold[%0d]: y_valid=%b s=%0d d=%h expected 1 2 a5",
                         i, y_valid, s, d);
            end
            @(negedge clk);
            nchecks++;
            if ({r3, r2, r1, r0} !== 4'b0000) begin
                nerrors++;
                $display("FAIL bp_stall_ready[%0d]: r=%b expected 0000", i, {r3, r2, r1, r0});
            end
        end
        v2 = 1'b0;
        y_ready = 1'b1;
        @(posedge clk); #1;
        nchecks++;
        if (y_valid !== 1'b0 || s !== 2'd2 || d !== 8'hA5) begin
            nerrors++;
            $display("FAIL bp_release: y_valid=%b s=%0d d=%h expected 0 2 a5", y_valid, s, d);
        end
        repeat (2) @(posedge clk);
        #1;
        nchecks++;
        if (cons[2] !== 1) begin
            nerrors++;
            $display("FAIL bp_consumed_once: count=%0d expected 1", cons[2]);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        v3 = 1'b1; y_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            d3 = 8'(k);
            #1;
            nchecks++;
            if ({r3, r2, r1, r0} !== 4'b1000) begin
                nerrors++;
                $display("FAIL single_ready[%0d]: r=%b expected 1000", k, {r3, r2, r1, r0});
            end
            @(posedge clk); #1;
            nchecks++;
            if (y_valid !== 1'b1 || s !== 2'd3 || d !== 8'(k)) begin
                nerrors++;
                $display("FAIL single_out[%0d]: y_valid=%b s=%0d d=%h expected 1 3 %h",
                         k, y_valid, s, d, 8'(k));
            end
            @(negedge clk);
        end
        v3 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        d0 = 8'h10; d1 = 8'h5C;
        v1 = 1'b1; y_ready = 1'b0;
        @(posedge clk); #1;
        nchecks++;
        if (y_valid !== 1'b1 || s !== 2'd1 || d !== 8'h5C) begin
            nerrors++;
            $display("FAIL midrst_load: y_valid=%b s=%0d d=%h expected 1 1 5c", y_valid, s, d);
        end
        @(negedge clk);
        v1 = 1'b0;
        #2;
        rst_n = 1'b0;
        v0 = 1'b1; v1 = 1'b1; v2 = 1'b1; v3 = 1'b1;
        #1;
        nchecks++;
        if (y_valid !== 1'b0 || s !== 2'd0 || d !== 8'h00 || {r3, r2, r1, r0} !== 4'b0000) begin
            nerrors++;
            $display("FAIL midrst_async: y_valid=%b s=%0d d=%h r=%b expected 0 0 00 0000",
                     y_valid, s, d, {r3, r2, r1, r0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        y_ready = 1'b1;
        #1;
        nchecks++;
        if ({r3, r2, r1, r0} !== 4'b0001) begin
            nerrors++;
            $display("FAIL midrst_first_ready: r=%b expected 0001", {r3, r2, r1, r0});
        end
        @(posedge clk); #1;
        nchecks++;
        if (y_valid !== 1'b1 || s !== 2'd0 || d !== 8'h10) begin
            nerrors++;
            $display("FAIL midrst_first_grant: y_valid=%b s=%0d d=%h expected 1 0 10", y_valid, s, d);
        end
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_demux();
        logic [3:0] y_start;
        logic [3:0] y_diff;
        @(negedge clk);
        for (int i = 0; i < 4; i++) cons[i] = 0;
        y_start = yd;
        d1 = 8'h21; d3 = 8'h43;
        v1 = 1'b1; v3 = 1'b1; y_ready = 1'b1;
        repeat (4) @(negedge clk);
        v1 = 1'b0; v3 = 1'b0;
        repeat (2) @(negedge clk);
        y_diff = yd ^ y_start;
        nchecks++;
        if (cons[0] !== 0 || cons[1] !== 2 || cons[2] !== 0 || cons[3] !== 2) begin
            nerrors++;
            $display("FAIL demux_counts: %0d %0d %0d %0d expected 0 2 0 2",
                     cons[0], cons[1], cons[2], cons[3]);
        end
        nchecks++;
        if (y_diff[0] !== 1'b0 || y_diff[2] !== 1'b0) begin
            nerrors++;
            $display("FAIL demux_idle_toggle: diff=%b expected bits 0 and 2 clear", y_diff);
        end
    endtask

    initial begin
        nchecks = 0;
        nerrors = 0;
        yd      = 4'b0000;
        for (int i = 0; i < 4; i++) cons[i] = 0;
        rst_n   = 1'b0;
        d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        y_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_single();
        test_mid_reset();
        test_demux();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
